// File: rtl/rom_port_pkg.sv
// Shared types for the toggle-handshake port responder.
//   state_t : responder FSM states
//   req_t   : latched port request {a, ds, we, d}; the address field is sized
//             to the widest supported port and zero-extended from AW bits
//   DS_NONE : byte-lane pattern that completes without a memory cycle
package rom_port_pkg;
  localparam int AW_MAX = 32;
  localparam logic [1:0] DS_NONE = 2'b00;

  typedef enum logic [1:0] {IDLE, REQ, RDWAIT} state_t;

  typedef struct packed {
    logic [AW_MAX-1:0] a;
    logic [1:0]        ds;
    logic              we;
    logic [15:0]       d;
  } req_t;
endpackage

// File: rtl/rom_port_responder.sv
// Memory-side responder for one toggle-handshake ROM/RAM port.
// A request is pending while i_port_req != o_port_ack. Each accepted request
// runs one 16-bit access on a synchronous ready/wait memory bus; o_port_ack
// toggles when it completes, with read data on o_port_q.
//   i_clk_sys, i_res_n       : clock, async active-low reset
//   i_port_req / o_port_ack  : request / acknowledge toggles
//   i_port_a/ds/we/d         : word address, byte lanes {hi,lo}, write flag, data
//   o_port_q                 : read data, held until the next read completes
//   o_busy                   : FSM not idle
//   o_mem_cs/we/be/a/d       : registered memory request, held until i_mem_ready
//   i_mem_q, i_mem_ready     : read data (READ_LAT cycles after ready), accept
module rom_port_responder
  import rom_port_pkg::*;
#(
  parameter int AW       = 23,
  parameter int READ_LAT = 1
) (
  input  logic          i_clk_sys,
  input  logic          i_res_n,
  input  logic          i_port_req,
  output logic          o_port_ack,
  input  logic [AW-1:0] i_port_a,
  input  logic [1:0]    i_port_ds,
  input  logic          i_port_we,
  input  logic [15:0]   i_port_d,
  output logic [15:0]   o_port_q,
  output logic          o_busy,
  output logic          o_mem_cs,
  output logic          o_mem_we,
  output logic [1:0]    o_mem_be,
  output logic [AW-1:0] o_mem_a,
  output logic [15:0]   o_mem_d,
  input  logic [15:0]   i_mem_q,
  input  logic          i_mem_ready
);

  state_t      r_state, w_state;
  logic [2:0]  r_cnt, w_cnt;
  req_t        r_req, w_req;
  logic        r_ack, w_ack;
  logic [15:0] r_q, w_q;
  logic        r_busy, w_busy;
  logic        r_cs, w_cs;
  logic        r_we, w_we;

  always_ff @(posedge i_clk_sys or negedge i_res_n) begin
    if (!i_res_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
      r_ack   <= 1'b0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_cs    <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_req   <= w_req;
      r_ack   <= w_ack;
      r_q     <= w_q;
      r_busy  <= w_busy;
      r_cs    <= w_cs;
      r_we    <= w_we;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_req   = r_req;
    w_ack   = r_ack;
    w_q     = r_q;
    w_cs    = r_cs;
    w_we    = r_we;
    case (r_state)
      IDLE: begin
        // Level compare: a re-toggle seen while busy is simply still pending here.
        if (i_port_req != r_ack) begin
          w_req = '{a: AW_MAX'(i_port_a), ds: i_port_ds, we: i_port_we, d: i_port_d};
          if (i_port_ds == DS_NONE) begin
            w_ack = ~r_ack;
          end else begin
            w_state = REQ;
            w_cs    = 1'b1;
            w_we    = i_port_we;
          end
        end
      end
      REQ: begin
        if (i_mem_ready) begin
          w_cs = 1'b0;
          w_we = 1'b0;
          if (r_req.we) begin
            w_ack   = ~r_ack;
            w_state = IDLE;
          end else if (READ_LAT == 0) begin
            w_q     = i_mem_q;
            w_ack   = ~r_ack;
            w_state = IDLE;
          end else begin
            w_cnt   = 3'(READ_LAT - 1);
            w_state = RDWAIT;
          end
        end
      end
      RDWAIT: begin
        // Whole word is captured; the requester picks its lanes.
        if (r_cnt == 3'd0) begin
          w_q     = i_mem_q;
          w_ack   = ~r_ack;
          w_state = IDLE;
        end else begin
          w_cnt = r_cnt - 3'd1;
        end
      end
      default: w_state = IDLE;
    endcase
    w_busy = (w_state != IDLE);
  end

  // Address bits above AW are always zero in the latched request.
  if (AW < AW_MAX) begin : g_pad
    logic w_unused_a;
    assign w_unused_a = ^r_req.a[AW_MAX-1:AW];
  end

  assign o_port_ack = r_ack;
  assign o_port_q   = r_q;
  assign o_busy     = r_busy;
  assign o_mem_cs   = r_cs;
  assign o_mem_we   = r_we;
  assign o_mem_be   = r_req.ds;
  assign o_mem_a    = r_req.a[AW-1:0];
  assign o_mem_d    = r_req.d;

endmodule
